load_align_ext_unit: RTL and testbench
======================================

Name: load_align_ext_unit

Overview:
- Multi-cycle load formatter between the datapath memory stage and data memory.
- Accepts one load request (address, size, signedness, destination tag) per handshake and issues an aligned word read to memory.
- Selects the addressed byte, halfword or word lane, then zero- or sign-extends it to DATA_W.
- Returns the result with its tag on a valid/ready output. Flags misaligned, illegal and timed-out accesses instead of reading.

Parameters:
- DATA_W, 32, memory word and result width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TAG_W, 5, destination-register tag width.
- BIG_ENDIAN, 0, 0 = byte k at data[8k+7:8k]; 1 = byte 0 at the most significant lane.
- TIMEOUT, 16, cycles allowed in WAIT before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 half, 10 word(32), 11 dword (legal only when DATA_W=64).
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- req_tag  in  TAG_W  destination tag.
- mem_rd_valid  out  1  memory read request.
- mem_rd_ready  in  1  memory accepts the read.
- mem_rd_addr  out  ADDR_W  req_addr with the low log2(DATA_W/8) bits cleared.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  DATA_W  read data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  extended result.
- out_tag  out  TAG_W  echoed request tag.
- out_err  out  2  00 ok, 01 misaligned, 10 illegal size, 11 timeout.

Behaviour:
- Reset (asynchronous, active-high) forces state IDLE; req_ready=1 and all other outputs 0, including mem_rd_addr, out_data, out_tag, out_err and the timeout counter. Reset mid-transaction drops the transaction; a late mem_rsp_valid after reset is ignored.
- States: IDLE, REQ, WAIT, DONE. req_ready=1 only in IDLE.
- IDLE: on req_valid, capture addr, size, signed and tag.
  - Illegal size: go to DONE with out_err=10.
  - Misaligned (half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0): go to DONE with out_err=01.
  - Otherwise go to REQ.
  - On any error path: out_data=0 and no memory request is issued.
- REQ: mem_rd_valid=1 with a stable mem_rd_addr until mem_rd_ready; then go to WAIT. mem_rsp_valid is ignored in REQ.
- WAIT: on mem_rsp_valid, select the lane from the captured offset and the BIG_ENDIAN rule.
  - Extend to DATA_W: fill = req_signed ? MSB of lane : 0. Register the result into out_data and go to DONE with out_err=00.
  - Counter increments each WAIT cycle. With TIMEOUT>0, when the count reaches TIMEOUT without a response, go to DONE with out_err=11 and out_data=0.
- DONE: out_valid=1; out_data, out_tag and out_err are held stable until out_ready, then go to IDLE. out_valid and req_ready are never both 1.
- Memory responses outside WAIT are ignored, including late responses after a timeout.
- Latency with zero-wait memory:
  - Request accepted at cycle T; mem_rd_valid at T+1.
  - Response sampled at T+2; out_valid at T+3.
  - Error paths: out_valid at T+1.
- Word load when DATA_W=32: no extension; req_signed is ignored.

Decomposition:
- Shared package holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - error codes ERR_OK/ERR_MISAL/ERR_ILL/ERR_TMO;
  - state encoding.
- One combinational sub-module, lane_select_ext: (data, offset, size, signed, BIG_ENDIAN) -> extended result. It is reused by a future store-path byte-enable generator.

Test Plan:
- LE, mem word 0x8A7FC3E1, zero-wait memory:
  - LB signed @0x1003 -> 0xFFFFFF8A, out_err=00, out_valid at T+3.
  - LBU @0x1001 -> 0x000000C3.
- LE, same word:
  - LH signed @0x1002 -> 0xFFFF8A7F.
  - LHU @0x1000 -> 0x0000C3E1.
  - LW @0x1000 -> 0x8A7FC3E1.
  - BIG_ENDIAN=1, LB @0x1000 -> 0xFFFFFF8A.
- Errors, checking that mem_rd_valid never asserts:
  - LH @0x1001 -> out_err=01, out_data=0, out_valid at T+1.
  - size=11 with DATA_W=32 -> out_err=10.
- Backpressure:
  - mem_rd_ready low 3 cycles -> mem_rd_addr stable.
  - out_ready low 4 cycles -> out_valid/out_data/out_tag stable, req_ready=0.
  - Second req_valid held during backpressure is accepted only after out_ready.
- TIMEOUT=4, no response:
  - out_err=11 after 4 WAIT cycles.
  - A late mem_rsp_valid with 0x12345678 is ignored.
  - The next LBU returns correct data.
- rst pulsed in WAIT (asynchronous, mid-cycle): outputs 0 immediately, req_ready=1, subsequent response ignored.

Source files
------------

// File: rtl/load_align_ext_unit_pkg.sv
// Shared encodings for the load formatter: access sizes, error codes and FSM states.
package load_align_ext_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_MISAL = 2'b01;
  localparam logic [1:0] ERR_ILL   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Dword accesses only exist on a 64-bit memory word.
  function automatic logic size_illegal(input logic [1:0] size, input int unsigned data_w);
    return (size == SZ_D) && (data_w < 64);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      SZ_H:    return lo[0] != 1'b0;
      SZ_W:    return lo[1:0] != 2'b00;
      SZ_D:    return lo != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext_unit_lane_select_ext.sv
// Picks the addressed byte/half/word lane out of a memory word and zero/sign-extends it.
module lane_select_ext
  import load_align_ext_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic [DATA_W-1:0]             data,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [1:0]                    size,
  input  logic                          is_signed,
  output logic [DATA_W-1:0]             result_c
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned MSB_W = $clog2(DATA_W);

  int unsigned       nbytes;
  int unsigned       lane;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic [MSB_W-1:0]  msb_idx;
  logic              fill;

  // Big-endian puts byte 0 in the top lane, so the lane index counts down from the top.
  always_comb begin
    nbytes = NB;
    case (size)
      SZ_B:    nbytes = 1;
      SZ_H:    nbytes = 2;
      SZ_W:    nbytes = 4;
      default: nbytes = NB;
    endcase
    lane     = (BIG_ENDIAN != 0) ? (NB - nbytes - 32'(offset)) : 32'(offset);
    shifted  = data >> (8 * lane);
    keep     = (nbytes >= NB) ? '1 : ((DATA_W'(1) << (8 * nbytes)) - DATA_W'(1));
    msb_idx  = MSB_W'(8 * nbytes - 1);
    fill     = is_signed & shifted[msb_idx];
    result_c = (shifted & keep) | ({DATA_W{fill}} & ~keep);
  end

endmodule

// File: rtl/load_align_ext_unit.sv
// Multi-cycle load formatter: checks the request, issues an aligned word read, returns the extended lane.
module load_align_ext_unit
  import load_align_ext_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned BIG_ENDIAN = 0,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mem_rd_valid,
  input  logic              mem_rd_ready,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        out_err
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               sgn_q, sgn_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  rd_addr_d;
  logic [DATA_W-1:0]  data_d;
  logic [TAG_W-1:0]   tag_d;
  logic [1:0]         err_d;
  logic [DATA_W-1:0]  lane_c;

  lane_select_ext #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane (
    .data      (mem_rsp_data),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (sgn_q),
    .result_c  (lane_c)
  );

  // Next-state and next-output logic; responses only matter in WAIT.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    rd_addr_d = mem_rd_addr;
    data_d    = out_data;
    tag_d     = out_tag;
    err_d     = out_err;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          off_d  = req_addr[OFF_W-1:0];
          size_d = req_size;
          sgn_d  = req_signed;
          tag_d  = req_tag;
          data_d = '0;
          cnt_d  = '0;
          if (size_illegal(req_size, DATA_W)) begin
            err_d   = ERR_ILL;
            state_d = ST_DONE;
          end else if (misaligned(req_size, req_addr[2:0])) begin
            err_d   = ERR_MISAL;
            state_d = ST_DONE;
          end else begin
            err_d     = ERR_OK;
            rd_addr_d = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_rd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          data_d  = lane_c;
          err_d   = ERR_OK;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
            data_d  = '0;
            err_d   = ERR_TMO;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      off_q        <= '0;
      size_q       <= SZ_B;
      sgn_q        <= 1'b0;
      cnt_q        <= '0;
      req_ready    <= 1'b1;
      mem_rd_valid <= 1'b0;
      mem_rd_addr  <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_tag      <= '0;
      out_err      <= ERR_OK;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      cnt_q        <= cnt_d;
      req_ready    <= (state_d == ST_IDLE);
      mem_rd_valid <= (state_d == ST_REQ);
      mem_rd_addr  <= rd_addr_d;
      out_valid    <= (state_d == ST_DONE);
      out_data     <= data_d;
      out_tag      <= tag_d;
      out_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_load_align_ext_unit.sv
// Directed bench for load_align_ext_unit: vector table plus backpressure, timeout and reset sequences.
module tb_load_align_ext_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [4:0]  req_tag = '0;
  logic        mem_rd_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        out_ready = 1'b1;

  logic        req_ready, mem_rd_valid, out_valid;
  logic [31:0] mem_rd_addr, out_data;
  logic [4:0]  out_tag;
  logic [1:0]  out_err;

  logic        be_req_ready, be_mem_rd_valid, be_out_valid;
  logic [31:0] be_mem_rd_addr, be_out_data;
  logic [4:0]  be_out_tag;
  logic [1:0]  be_out_err;

  logic        mem_auto = 1'b1;
  logic        rsp_force = 1'b0;
  logic [31:0] force_data = '0;
  logic        hs = 1'b0;
  localparam logic [31:0] MEM_WORD = 32'h8A7FC3E1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load_align_ext_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(5), .BIG_ENDIAN(0), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_tag(req_tag), .mem_rd_valid(mem_rd_valid),
    .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err));

  load_align_ext_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(5), .BIG_ENDIAN(1), .TIMEOUT(4)) dut_be (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(be_req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_tag(req_tag), .mem_rd_valid(be_mem_rd_valid),
    .mem_rd_ready(mem_rd_ready), .mem_rd_addr(be_mem_rd_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .out_valid(be_out_valid), .out_ready(out_ready), .out_data(be_out_data),
    .out_tag(be_out_tag), .out_err(be_out_err));

  // Zero-wait memory: answers in the cycle after the read handshake; rsp_force injects stray responses.
  initial forever begin
    @(posedge clk);
    hs = mem_rd_valid && mem_rd_ready;
    @(negedge clk);
    mem_rsp_valid = (hs && mem_auto) || rsp_force;
    mem_rsp_data  = rsp_force ? force_data : MEM_WORD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Waits (bounded) for out_valid, noting whether a memory read was seen on the way.
  task automatic wait_out(output int n, output logic saw_rd);
    n = 0;
    saw_rd = 1'b0;
    while (!out_valid && n < 20) begin
      if (mem_rd_valid) saw_rd = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (mem_rd_valid) saw_rd = 1'b1;
    check("out_valid_within_budget", 32'(out_valid), 32'd1);
  endtask

  task automatic send_req(input logic [31:0] a, input logic [1:0] s, input logic sg, input logic [4:0] t);
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = s;
    req_signed = sg;
    req_tag    = t;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    int          exp_lat;
    logic        exp_rd;
    logic [31:0] exp_be;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input int i);
    int   n;
    logic saw;
    @(negedge clk);
    send_req(vecs[i].addr, vecs[i].size, vecs[i].sgn, 5'(i + 1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_out(n, saw);
    check($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
    check($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
    check($sformatf("v%0d_tag", i), 32'(out_tag), 32'(i + 1));
    check($sformatf("v%0d_latency", i), 32'(n + 1), 32'(vecs[i].exp_lat));
    check($sformatf("v%0d_mem_rd_seen", i), 32'(saw), 32'(vecs[i].exp_rd));
    check($sformatf("v%0d_be_data", i), be_out_data, vecs[i].exp_be);
    @(posedge clk); #1;
  endtask

  initial begin
    int   n;
    logic saw;
    logic [31:0] hold_data;

    vecs[0]  = '{32'h1003, 2'b00, 1'b1, 32'hFFFFFF8A, 2'b00, 3, 1'b1, 32'hFFFFFFE1};
    vecs[1]  = '{32'h1001, 2'b00, 1'b0, 32'h000000C3, 2'b00, 3, 1'b1, 32'h0000007F};
    vecs[2]  = '{32'h1002, 2'b01, 1'b1, 32'hFFFF8A7F, 2'b00, 3, 1'b1, 32'hFFFFC3E1};
    vecs[3]  = '{32'h1000, 2'b01, 1'b0, 32'h0000C3E1, 2'b00, 3, 1'b1, 32'h00008A7F};
    vecs[4]  = '{32'h1000, 2'b10, 1'b1, 32'h8A7FC3E1, 2'b00, 3, 1'b1, 32'h8A7FC3E1};
    vecs[5]  = '{32'h1000, 2'b00, 1'b1, 32'hFFFFFFE1, 2'b00, 3, 1'b1, 32'hFFFFFF8A};
    vecs[6]  = '{32'h1002, 2'b00, 1'b1, 32'h0000007F, 2'b00, 3, 1'b1, 32'hFFFFFFC3};
    vecs[7]  = '{32'h1000, 2'b10, 1'b0, 32'h8A7FC3E1, 2'b00, 3, 1'b1, 32'h8A7FC3E1};
    vecs[8]  = '{32'h1001, 2'b01, 1'b1, 32'h00000000, 2'b01, 1, 1'b0, 32'h00000000};
    vecs[9]  = '{32'h1002, 2'b10, 1'b0, 32'h00000000, 2'b01, 1, 1'b0, 32'h00000000};
    vecs[10] = '{32'h1003, 2'b01, 1'b0, 32'h00000000, 2'b01, 1, 1'b0, 32'h00000000};
    vecs[11] = '{32'h1000, 2'b11, 1'b0, 32'h00000000, 2'b10, 1, 1'b0, 32'h00000000};
    vecs[12] = '{32'h1001, 2'b11, 1'b1, 32'h00000000, 2'b10, 1, 1'b0, 32'h00000000};

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_rd_valid", 32'(mem_rd_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_mem_rd_addr", mem_rd_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Memory read backpressure: address must stay stable
    @(negedge clk);
    mem_rd_ready = 1'b0;
    send_req(32'h1001, 2'b00, 1'b0, 5'd7);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rdbp_valid_%0d", k), 32'(mem_rd_valid), 32'd1);
      check($sformatf("rdbp_addr_%0d", k), mem_rd_addr, 32'h1000);
      @(posedge clk); #1;
    end
    mem_rd_ready = 1'b1;
    wait_out(n, saw);
    check("rdbp_data", out_data, 32'h000000C3);
    check("rdbp_tag", 32'(out_tag), 32'd7);
    check("rdbp_cycles", 32'(n), 32'd2);
    @(posedge clk); #1;

    // Output backpressure with a second request held pending
    @(negedge clk);
    out_ready = 1'b0;
    send_req(32'h1000, 2'b10, 1'b0, 5'd3);
    @(posedge clk); #1;
    send_req(32'h1003, 2'b00, 1'b0, 5'd9);
    wait_out(n, saw);
    check("obp_data", out_data, MEM_WORD);
    hold_data = out_data;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("obp_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("obp_data_%0d", k), out_data, hold_data);
      check($sformatf("obp_tag_%0d", k), 32'(out_tag), 32'd3);
      check($sformatf("obp_req_ready_%0d", k), 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("obp_release_req_ready", 32'(req_ready), 32'd1);
    check("obp_release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("obp_second_accepted", 32'(mem_rd_valid), 32'd1);
    wait_out(n, saw);
    check("obp_second_data", out_data, 32'h0000008A);
    check("obp_second_tag", 32'(out_tag), 32'd9);
    @(posedge clk); #1;

    // Timeout with no response, then a late response that must be ignored
    mem_auto = 1'b0;
    @(negedge clk);
    send_req(32'h1001, 2'b00, 1'b0, 5'd4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_out(n, saw);
    check("tmo_err", 32'(out_err), 32'd3);
    check("tmo_data", out_data, 32'd0);
    check("tmo_tag", 32'(out_tag), 32'd4);
    check("tmo_latency", 32'(n + 1), 32'd6);
    force_data = 32'h12345678;
    rsp_force  = 1'b1;
    @(posedge clk); #1;
    check("tmo_late_out_valid_a", 32'(out_valid), 32'd0);
    check("tmo_late_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("tmo_late_out_valid_b", 32'(out_valid), 32'd0);
    check("tmo_late_out_data", out_data, 32'd0);
    rsp_force = 1'b0;
    mem_auto  = 1'b1;
    @(posedge clk); #1;
    run_vec(1);

    // Asynchronous reset while waiting for the response
    mem_auto = 1'b0;
    @(negedge clk);
    send_req(32'h1000, 2'b10, 1'b0, 5'd5);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_mem_rd_valid", 32'(mem_rd_valid), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_out_tag", 32'(out_tag), 32'd0);
    check("arst_mem_rd_addr", mem_rd_addr, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    force_data = 32'h12345678;
    rsp_force  = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("arst_late_out_valid", 32'(out_valid), 32'd0);
    check("arst_late_out_data", out_data, 32'd0);
    check("arst_late_req_ready", 32'(req_ready), 32'd1);
    rsp_force = 1'b0;
    mem_auto  = 1'b1;
    @(posedge clk); #1;
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
